// File: rtl/read_pointer_empty.sv
// Read-side pointer and empty/level tracking for an asynchronous FIFO.
// Keeps a binary and a Gray read pointer. Produces a registered empty flag,
// almost-empty flag and fill level from the synchronized Gray write pointer.
// Optional sticky underflow detection is enabled with the RD_UNDERFLOW_DET_EN
// macro. When the macro is undefined, rd_underflow is tied to 0.
module read_pointer_empty #(
  parameter int unsigned ADDRSIZE      = 4,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                rd_clk,
  input  logic                rrst,
  input  logic                rd_en,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic                rd_empty,
  output logic                rd_almost_empty,
  output logic [ADDRSIZE-1:0] rd_addr,
  output logic [ADDRSIZE:0]   rptr,
  output logic [ADDRSIZE:0]   rd_level,
  output logic                rd_underflow
);

  localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] rbin_q, rbin_d;
  logic [ADDRSIZE:0] rptr_q, rgray_d;
  logic [ADDRSIZE:0] level_q, level_d;
  logic [ADDRSIZE:0] wbin_s;
  logic              empty_q, empty_d;
  logic              aempty_q, aempty_d;
  logic              rd_valid;

  // Next pointer values, write-pointer decode and the flags derived from them.
  always_comb begin
    rd_valid = rd_en & ~empty_q;
    rbin_d   = rbin_q + {{ADDRSIZE{1'b0}}, rd_valid};
    rgray_d  = (rbin_d >> 1) ^ rbin_d;
    wbin_s   = rq2_wptr;
    for (int unsigned i = 1; i <= ADDRSIZE; i++) begin
      wbin_s = wbin_s ^ (rq2_wptr >> i);
    end
    // Comparing against the next read pointer makes empty assert on the
    // same edge that consumes the last entry.
    level_d  = wbin_s - rbin_d;
    empty_d  = (rgray_d == rq2_wptr);
    aempty_d = (level_d <= THRESH);
  end

  // Pointer and status registers; synchronous reset wins over reads.
  always_ff @(posedge rd_clk) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rgray_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
    end
  end

  assign rd_addr         = rbin_q[ADDRSIZE-1:0];
  assign rptr            = rptr_q;
  assign rd_level        = level_q;
  assign rd_empty        = empty_q;
  assign rd_almost_empty = aempty_q;

`ifdef RD_UNDERFLOW_DET_EN
  logic underflow_q;

  // Sticky flag set by any read attempt while empty; cleared only by reset.
  always_ff @(posedge rd_clk) begin
    if (rrst) begin
      underflow_q <= 1'b0;
    end else if (rd_en & empty_q) begin
      underflow_q <= 1'b1;
    end
  end

  assign rd_underflow = underflow_q;
`else
  assign rd_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_read_pointer_empty.sv
// Self-checking bench for read_pointer_empty (ADDRSIZE=4, AEMPTY_THRESH=2).
// Reference model: unbounded read/write entry counts with level = written - read.
module tb_read_pointer_empty;

`ifdef RD_UNDERFLOW_DET_EN
  localparam bit UF_EN = 1'b1;
`else
  localparam bit UF_EN = 1'b0;
`endif

  logic       rd_clk = 1'b0;
  logic       rrst = 1'b1;
  logic       rd_en = 1'b0;
  logic [4:0] rq2_wptr = '0;
  logic       rd_empty, rd_almost_empty, rd_underflow;
  logic [3:0] rd_addr;
  logic [4:0] rptr, rd_level;
  logic [16:0] obs;

  int vectors = 0;
  int miscompares = 0;

  // Model state
  int   m_rd = 0;
  int   m_wr = 0;
  int   m_level = 0;
  bit   m_empty = 1'b1;
  bit   m_aempty = 1'b1;
  bit   m_uf = 1'b0;

  read_pointer_empty #(.ADDRSIZE(4), .AEMPTY_THRESH(2)) dut (
    .rd_clk          (rd_clk),
    .rrst            (rrst),
    .rd_en           (rd_en),
    .rq2_wptr        (rq2_wptr),
    .rd_empty        (rd_empty),
    .rd_almost_empty (rd_almost_empty),
    .rd_addr         (rd_addr),
    .rptr            (rptr),
    .rd_level        (rd_level),
    .rd_underflow    (rd_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  assign obs = {rd_empty, rd_almost_empty, rd_addr, rptr, rd_level, rd_underflow};

  function automatic logic [4:0] gray5(input int v);
    logic [4:0] b;
    b = 5'(v % 32);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [16:0] model_vec();
    logic [3:0] a;
    a = 4'(m_rd % 16);
    return {m_empty, m_aempty, a, gray5(m_rd), 5'(m_level), m_uf};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle past it.
  task automatic step(input logic rst, input logic en, input int wr);
    rrst = rst;
    rd_en = en;
    rq2_wptr = gray5(wr);
    m_wr = wr;
    @(posedge rd_clk);
    if (rst) begin
      m_rd = 0; m_level = 0; m_empty = 1'b1; m_aempty = 1'b1; m_uf = 1'b0;
    end else begin
      if (en && m_empty && UF_EN) m_uf = 1'b1;
      if (en && !m_empty) m_rd++;
      m_level  = wr - m_rd;
      m_empty  = (m_level == 0);
      m_aempty = (m_level <= 2);
    end
    #1;
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 0);
    vectors++;
    if (obs !== 17'b1_1_0000_00000_00000_0) begin
      miscompares++;
      $display("FAIL reset_state got %h exp %h", obs, 17'b1_1_0000_00000_00000_0);
    end
    vectors++;
    if (obs !== model_vec()) begin
      miscompares++;
      $display("FAIL reset_model got %h exp %h", obs, model_vec());
    end
  endtask

  task automatic test_fill();
    step(1'b0, 1'b0, 3);
    vectors++;
    if (rd_empty !== 1'b0 || rd_level !== 5'd3 || rd_almost_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL fill3 got empty=%b level=%0d ae=%b exp empty=0 level=3 ae=0",
               rd_empty, rd_level, rd_almost_empty);
    end
  endtask

  task automatic test_read_burst();
    logic [3:0] ea [4];
    logic [4:0] ep [4];
    logic [4:0] el [4];
    logic       ee [4];
    ea = '{4'd1, 4'd2, 4'd3, 4'd3};
    ep = '{5'b00001, 5'b00011, 5'b00010, 5'b00010};
    el = '{5'd2, 5'd1, 5'd0, 5'd0};
    ee = '{1'b0, 1'b0, 1'b1, 1'b1};
    vectors++;
    if (rd_addr !== 4'd0) begin
      miscompares++;
      $display("FAIL burst_addr0 got %0d exp 0", rd_addr);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 3);
      vectors++;
      if (rd_addr !== ea[i] || rptr !== ep[i] || rd_level !== el[i] ||
          rd_empty !== ee[i] || rd_almost_empty !== 1'b1) begin
        miscompares++;
        $display("FAIL burst_%0d got addr=%0d rptr=%b lvl=%0d e=%b ae=%b exp addr=%0d rptr=%b lvl=%0d e=%b ae=1",
                 i, rd_addr, rptr, rd_level, rd_empty, rd_almost_empty, ea[i], ep[i], el[i], ee[i]);
      end
      vectors++;
      if (obs !== model_vec()) begin
        miscompares++;
        $display("FAIL burst_model_%0d got %h exp %h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 16);
    vectors++;
    if (rd_level !== 5'd16 || rd_empty !== 1'b0 || rd_almost_empty !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_full got lvl=%0d e=%b ae=%b exp lvl=16 e=0 ae=0",
               rd_level, rd_empty, rd_almost_empty);
    end
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 1'b1, 16);
      vectors++;
      if (obs !== model_vec()) begin
        miscompares++;
        $display("FAIL wrap_model_%0d got %h exp %h", i, obs, model_vec());
      end
      if (i == 15) begin
        vectors++;
        if (rd_addr !== 4'd15) begin
          miscompares++;
          $display("FAIL wrap_addr15 got %0d exp 15", rd_addr);
        end
      end
    end
    vectors++;
    if (rd_addr !== 4'd0 || rptr !== 5'b11000 || rd_empty !== 1'b1 || rd_level !== 5'd0) begin
      miscompares++;
      $display("FAIL wrap_end got addr=%0d rptr=%b e=%b lvl=%0d exp addr=0 rptr=11000 e=1 lvl=0",
               rd_addr, rptr, rd_empty, rd_level);
    end
  endtask

  task automatic test_underflow();
    logic [4:0] p0;
    p0 = rptr;
    step(1'b0, 1'b1, m_wr);
    vectors++;
    if (rd_underflow !== UF_EN || rptr !== p0) begin
      miscompares++;
      $display("FAIL underflow_set got uf=%b rptr=%b exp uf=%b rptr=%b", rd_underflow, rptr, UF_EN, p0);
    end
    step(1'b0, 1'b0, m_wr);
    step(1'b0, 1'b1, m_wr + 1);
    vectors++;
    if (rd_underflow !== UF_EN || rd_level !== 5'd1) begin
      miscompares++;
      $display("FAIL underflow_sticky got uf=%b lvl=%0d exp uf=%b lvl=1", rd_underflow, rd_level, UF_EN);
    end
  endtask

  task automatic test_random();
    int wr;
    wr = m_wr;
    for (int i = 0; i < 400; i++) begin
      logic rst;
      rst = ($urandom_range(0, 79) == 0);
      if (rst) begin
        wr = 0;
      end else if (wr - m_rd < 16) begin
        wr = wr + int'($urandom_range(0, 2));
        if (wr - m_rd > 16) wr = m_rd + 16;
      end
      step(rst, 1'($urandom_range(0, 1)), wr);
      vectors++;
      if (obs !== model_vec()) begin
        miscompares++;
        $display("FAIL random_%0d got %h exp %h", i, obs, model_vec());
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 6);
    step(1'b0, 1'b1, 6);
    vectors++;
    if (rd_level !== 5'd5) begin
      miscompares++;
      $display("FAIL midburst_level got %0d exp 5", rd_level);
    end
    step(1'b1, 1'b1, 6);
    vectors++;
    if (obs !== 17'b1_1_0000_00000_00000_0) begin
      miscompares++;
      $display("FAIL midburst_reset got %h exp %h", obs, 17'b1_1_0000_00000_00000_0);
    end
    step(1'b0, 1'b1, 6);
    vectors++;
    if (obs !== model_vec()) begin
      miscompares++;
      $display("FAIL post_reset got %h exp %h", obs, model_vec());
    end
    step(1'b0, 1'b1, 6);
    vectors++;
    if (rd_addr !== 4'd1 || rd_level !== 5'd5 || obs !== model_vec()) begin
      miscompares++;
      $display("FAIL post_reset_read got %h exp %h", obs, model_vec());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read_burst();
    test_wrap();
    test_underflow();
    test_random();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
